// File: rtl/caravel_clock_ctrl_pkg.sv
// Shared types and defaults for the clocking-block reconfiguration sequencer.
// Imported by the sequencer top and its testbench.
package caravel_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_PLL_ON,
        ST_APPLY,
        ST_SYNC,
        ST_RELEASE
    } state_t;

    typedef struct packed {
        logic       ext_sel;
        logic [2:0] sel;
        logic [2:0] sel2;
    } clk_cfg_t;

    localparam int DEF_HOLD_CYCLES   = 4;
    localparam int DEF_SETTLE_CYCLES = 1000;
    localparam int DEF_SYNC_CYCLES   = 8;

    // Power-up clocking: external pad clock, both dividers at 0.
    localparam clk_cfg_t CFG_RESET = '{ext_sel: 1'b1, sel: 3'd0, sel2: 3'd0};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/caravel_clock_ctrl_if.sv
// Housekeeping request channel into the clock sequencer (valid/ready handshake).
interface caravel_clock_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_ext_sel;
    logic [2:0] req_sel;
    logic [2:0] req_sel2;
    logic       req_pll_off;

    modport master (
        output req_valid, req_ext_sel, req_sel, req_sel2, req_pll_off,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_ext_sel, req_sel, req_sel2, req_pll_off,
        output req_ready
    );

endinterface

// File: rtl/caravel_clock_ctrl_timer.sv
// Loadable down-counter with zero flag; shared by the hold, PLL-settle and sync waits.
module clock_ctrl_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/caravel_clock_ctrl.sv
// Glitch-free clocking reconfiguration: holds the core in reset, brings up the PLL
// if needed, applies the new select/divider values, then releases the core.
module caravel_clock_ctrl
    import caravel_clock_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_CYCLES   = DEF_SYNC_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    caravel_clock_ctrl_if.slave  hk,
    output logic                 ext_clk_sel,
    output logic [2:0]           sel,
    output logic [2:0]           sel2,
    output logic                 pll_ena,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, SETTLE_CYCLES, SYNC_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LD   = CNT_W'(SYNC_CYCLES - 1);

    state_t           state;
    clk_cfg_t         cur_cfg;
    clk_cfg_t         cap_cfg;
    clk_cfg_t         req_cfg;
    logic             cap_pll_off;
    logic             ready_q;
    logic             handshake;
    logic             pll_match;
    logic             no_change;
    logic             need_pll;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    assign req_cfg   = {hk.req_ext_sel, hk.req_sel, hk.req_sel2};
    assign handshake = hk.req_valid && ready_q;

    // The PLL matches if a PLL request finds it running, or an external request leaves it as-is.
    assign pll_match = hk.req_ext_sel ? (!hk.req_pll_off || !pll_ena) : pll_ena;
    assign no_change = (req_cfg == cur_cfg) && pll_match;
    assign need_pll  = !cap_cfg.ext_sel && !pll_ena;

    // Timer is loaded on the same edge that enters a timed state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (handshake && !no_change) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero && need_pll) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            ST_APPLY: begin
                tmr_load = 1'b1;
                tmr_val  = SYNC_LD;
            end
            default: ;
        endcase
    end

    clock_ctrl_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_cfg     <= CFG_RESET;
            cap_cfg     <= CFG_RESET;
            cap_pll_off <= 1'b0;
            pll_ena     <= 1'b0;
            core_hold   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        cap_cfg     <= req_cfg;
                        cap_pll_off <= hk.req_pll_off;
                        ready_q     <= 1'b0;
                        busy        <= 1'b1;
                        if (no_change) begin
                            state <= ST_RELEASE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_HOLD;
                            core_hold <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        if (need_pll) begin
                            state   <= ST_PLL_ON;
                            pll_ena <= 1'b1;
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                end
                ST_PLL_ON: begin
                    if (tmr_zero) begin
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    cur_cfg <= cap_cfg;
                    state   <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (tmr_zero) begin
                        state     <= ST_RELEASE;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // PLL may only drop once the core is already running from the pad clock.
                    if (cap_cfg.ext_sel && cap_pll_off) begin
                        pll_ena <= 1'b0;
                    end
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ext_clk_sel  = cur_cfg.ext_sel;
    assign sel          = cur_cfg.sel;
    assign sel2         = cur_cfg.sel2;
    assign hk.req_ready = ready_q;

endmodule

// File: tb/tb_caravel_clock_ctrl.sv
// Self-checking bench for caravel_clock_ctrl: per-cycle trace checks plus a done-time scoreboard.
module tb_caravel_clock_ctrl;
    import caravel_clock_pkg::*;

    localparam int HOLD   = 2;
    localparam int SETTLE = 5;
    localparam int SYNC   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_clk_sel;
    logic [2:0] sel;
    logic [2:0] sel2;
    logic       pll_ena;
    logic       core_hold;
    logic       busy;
    logic       done;

    caravel_clock_ctrl_if bus ();

    caravel_clock_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .SYNC_CYCLES   (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hk          (bus),
        .ext_clk_sel (ext_clk_sel),
        .sel         (sel),
        .sel2        (sel2),
        .pll_ena     (pll_ena),
        .core_hold   (core_hold),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        clk_cfg_t cfg;
        logic     pll;
        int       done_cyc;
    } exp_t;

    exp_t     sb[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    clk_cfg_t m_cfg;
    logic     m_pll;

    // Drive one request at a negedge and follow it cycle by cycle; cycle 0 is the handshake.
    task automatic run_req(input logic ext, input logic [2:0] s, input logic [2:0] s2,
                           input logic off, input bit spam);
        clk_cfg_t oc, nc, exp_cfg;
        logic     op, fp, ident, need_pll, exp_pll;
        int       d, v;
        exp_t     e, got;
        bit       have_got;
        oc       = m_cfg;
        op       = m_pll;
        nc       = '{ext_sel: ext, sel: s, sel2: s2};
        fp       = ext ? (off ? 1'b0 : op) : 1'b1;
        ident    = (nc == oc) && (fp == op);
        need_pll = !ext && !op;
        if (ident)         d = 1;
        else if (need_pll) d = HOLD + SETTLE + SYNC + 2;
        else               d = HOLD + SYNC + 2;
        v          = ident ? 1 : d - SYNC;
        e.cfg      = nc;
        e.pll      = fp;
        e.done_cyc = d;
        sb.push_back(e);
        have_got = 0;

        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle: got %b want 1", bus.req_ready);
        end
        bus.req_valid   = 1'b1;
        bus.req_ext_sel = ext;
        bus.req_sel     = s;
        bus.req_sel2    = s2;
        bus.req_pll_off = off;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            exp_cfg = (k >= v) ? nc : oc;
            exp_pll = (k > d) ? fp : (need_pll ? (k >= HOLD + 1) : op);
            n_checks++;
            if ({ext_clk_sel, sel, sel2} !== exp_cfg) begin
                n_fail++;
                $display("FAIL cfg cyc%0d: got %h want %h", k, {ext_clk_sel, sel, sel2}, exp_cfg);
            end
            n_checks++;
            if (pll_ena !== exp_pll) begin
                n_fail++;
                $display("FAIL pll_ena cyc%0d: got %b want %b", k, pll_ena, exp_pll);
            end
            n_checks++;
            if (core_hold !== (!ident && k < d)) begin
                n_fail++;
                $display("FAIL core_hold cyc%0d: got %b want %b", k, core_hold, (!ident && k < d));
            end
            n_checks++;
            if (done !== (k == d)) begin
                n_fail++;
                $display("FAIL done cyc%0d: got %b want %b", k, done, (k == d));
            end
            n_checks++;
            if (busy !== (k <= d) || bus.req_ready !== (k > d)) begin
                n_fail++;
                $display("FAIL busy_ready cyc%0d: got %b/%b want %b/%b", k, busy, bus.req_ready,
                         (k <= d), (k > d));
            end
            if (done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_done cyc%0d: got done want none", k);
                end else begin
                    got      = sb.pop_front();
                    have_got = 1;
                    if (k != got.done_cyc || {ext_clk_sel, sel, sel2} !== got.cfg) begin
                        n_fail++;
                        $display("FAIL sb_done: got cyc%0d cfg %h want cyc%0d cfg %h", k,
                                 {ext_clk_sel, sel, sel2}, got.done_cyc, got.cfg);
                    end
                end
            end
            if (spam) begin
                if (k >= 2 && k < d) begin
                    bus.req_valid   = 1'b1;
                    bus.req_ext_sel = ~ext;
                    bus.req_sel     = ~s;
                    bus.req_sel2    = ~s2;
                    bus.req_pll_off = 1'b1;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (!have_got || sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_done_missing: got pending %0d want 0", sb.size());
            sb.delete();
        end else if (pll_ena !== got.pll) begin
            n_fail++;
            $display("FAIL sb_final_pll: got %b want %b", pll_ena, got.pll);
        end
        m_cfg = nc;
        m_pll = fp;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_ext_sel = 1'b0;
        bus.req_sel     = 3'd0;
        bus.req_sel2    = 3'd0;
        bus.req_pll_off = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ext_clk_sel, sel, sel2} !== CFG_RESET || pll_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cfg: got %h pll %b want %h pll 0", {ext_clk_sel, sel, sel2},
                     pll_ena, CFG_RESET);
        end
        n_checks++;
        if (core_hold !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: got hold%b busy%b done%b rdy%b want 0 0 0 1",
                     core_hold, busy, done, bus.req_ready);
        end
        m_cfg = CFG_RESET;
        m_pll = 1'b0;
    endtask

    task automatic test_full_pll();
        run_req(1'b0, 3'd2, 3'd3, 1'b0, 1'b0);
    endtask

    task automatic test_divider_only();
        run_req(1'b0, 3'd4, 3'd3, 1'b0, 1'b0);
    endtask

    task automatic test_to_external();
        run_req(1'b1, 3'd4, 3'd3, 1'b1, 1'b0);
    endtask

    task automatic test_identical();
        run_req(1'b1, 3'd4, 3'd3, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_req(1'b0, 3'd1, 3'd5, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || {ext_clk_sel, sel, sel2} !== m_cfg) begin
                n_fail++;
                $display("FAIL busy_ignore_after: got done%b busy%b cfg %h want 0 0 %h",
                         done, busy, {ext_clk_sel, sel, sel2}, m_cfg);
            end
        end
    endtask

    task automatic test_reset_in_pll_on();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_cfg = CFG_RESET;
        m_pll = 1'b0;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_ext_sel = 1'b0;
        bus.req_sel     = 3'd6;
        bus.req_sel2    = 3'd2;
        bus.req_pll_off = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (HOLD + 2) @(negedge clk);
        n_checks++;
        if (pll_ena !== 1'b1 || core_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL pll_on_entry: got pll%b hold%b want 1 1", pll_ena, core_hold);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (pll_ena !== 1'b0 || core_hold !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1 ||
            {ext_clk_sel, sel, sel2} !== CFG_RESET) begin
            n_fail++;
            $display("FAIL async_reset: got pll%b hold%b busy%b rdy%b cfg %h want 0 0 0 1 %h",
                     pll_ena, core_hold, busy, bus.req_ready, {ext_clk_sel, sel, sel2}, CFG_RESET);
        end
        @(negedge clk);
        reset = 1'b0;
        run_req(1'b0, 3'd6, 3'd2, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_pll();
        test_divider_only();
        test_to_external();
        test_identical();
        test_busy_ignore();
        test_reset_in_pll_on();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
